matrix_result_streamer: RTL
===========================

MATRIX_RESULT_STREAMER -- requirements
Module: matrix_result_streamer

Interface
REQ-001 SHALL have parameter SIZE, default 4, meaning matrix dimension (SIZE x SIZE, legal range 2..16).
REQ-002 SHALL have parameter DATA_W, default 32, meaning element width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port mat, input, DATA_W x [0:SIZE-1][0:SIZE-1]: result matrix from the multiplier.
REQ-006 SHALL have port mat_done, input, 1 bit: level from the multiplier, high when mat is final.
REQ-007 SHALL have port out_data, output, DATA_W: streamed element.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: sink accepts the element.
REQ-010 SHALL have port out_last, output, 1 bit: the current element is [SIZE-1][SIZE-1].
REQ-011 SHALL have ports out_row and out_col, output, $clog2(SIZE) bits each: indices of the current element.
REQ-012 SHALL have port busy, output, 1 bit: high in CAPTURE or STREAM.
REQ-013 SHALL have port stream_done, output, 1 bit: one-cycle pulse after the last handshake.
REQ-014 SHALL have port overrun, output, 1 bit: sticky error flag.

Function
REQ-015 SHALL implement states IDLE, CAPTURE, STREAM and FINISH.
REQ-016 SHALL register mat_done each cycle and detect a rising edge (current 1, previous 0).
REQ-017 IDLE -> CAPTURE on a rising edge of mat_done; an already-high level at reset release SHALL NOT trigger.
REQ-018 CAPTURE SHALL last exactly one cycle: copy all of mat into an internal snapshot buffer, set row=col=0, then go to STREAM.
REQ-019 In STREAM, out_valid SHALL be 1 and out_data SHALL equal snapshot[out_row][out_col]; first out_valid is 2 cycles after the mat_done rising edge.
REQ-020 Order SHALL be row-major; a handshake (out_valid && out_ready) advances col; col wraps from SIZE-1 to 0 and increments row.
REQ-021 While out_ready is 0, out_data, out_row, out_col and out_last SHALL hold stable.
REQ-022 out_last SHALL be 1 only when out_valid=1 and row=col=SIZE-1.
REQ-023 A handshake on the last element SHALL move STREAM -> FINISH; FINISH asserts stream_done for one cycle, then goes to IDLE.
REQ-024 Back-to-back streaming: with out_ready held 1, exactly SIZE*SIZE consecutive valid cycles SHALL occur.
REQ-025 Changes to mat after CAPTURE SHALL NOT affect streamed data.
REQ-026 A mat_done rising edge outside IDLE SHALL be ignored for streaming and SHALL set overrun, which stays set until reset.
REQ-027 A mat_done rising edge in the FINISH cycle SHALL also set overrun and SHALL NOT start a new capture.
REQ-028 mat_done staying high after FINISH SHALL NOT restart streaming; a fall and a new rise are required.
REQ-029 Element values SHALL pass through unmodified, with no width conversion or arithmetic.

Reset
REQ-030 When rst_n=0 at a clock edge, the block SHALL enter IDLE, even mid-stream.
REQ-031 Reset values: out_valid=0, out_last=0, out_data=0, out_row=0, out_col=0, busy=0, stream_done=0, overrun=0, registered mat_done=0.
REQ-032 The snapshot buffer need not be reset.

Structure
REQ-033 A shared package matrix_pkg SHALL hold DATA_W default, the state enum type and an index-width function.
REQ-034 One sub-module, rise_detect (1-bit registered rising-edge detector with synchronous active-low reset), SHALL be used for mat_done.

Verification
REQ-035 SIZE=2, mat={{1,2},{3,4}}, rise of mat_done, out_ready=1 -> out_data 1,2,3,4 on 4 consecutive cycles starting 2 cycles after the rise; out_last only on 4; stream_done pulses once.
REQ-036 SIZE=3, out_ready toggling 1,0,1,0 -> 9 handshakes in order 0..8; data and indices stable during stall cycles.
REQ-037 Change mat to all 0xFFFFFFFF right after CAPTURE -> streamed values equal the captured snapshot.
REQ-038 Pulse mat_done low->high during STREAM -> overrun=1, stream completes normally, no second stream occurs.
REQ-039 rst_n=0 after the 2nd handshake of a SIZE=2 stream -> next cycle out_valid=0, IDLE; a new rise streams from [0][0].
REQ-040 mat_done high through reset release and held high -> no stream; drop, then raise -> one full stream.

Source files
------------

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared types and helpers for the matrix result streamer
package matrix_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_STREAM  = 2'd2,
        ST_FINISH  = 2'd3
    } state_t;

    // Width of a row/column index for a size x size matrix (never below 1 bit).
    function automatic int idx_w(input int size);
        return (size < 2) ? 1 : $clog2(size);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - registered 1-bit rising-edge detector
// Ports: clk, rst_n (sync active-low), d (level in), rise (d high now, low last cycle).
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic prev;
    logic armed;

    // armed stays low for the first cycle after reset so a level that is
    // already high when reset releases is not mistaken for a new edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= d;
            armed <= 1'b1;
        end
    end

    assign rise = armed & d & ~prev;

endmodule

// File: rtl/matrix_result_streamer.sv
// rtl/matrix_result_streamer.sv - snapshots a finished matrix and streams it row-major
// Ports: clk, rst_n (sync active-low); mat/mat_done from the multiplier;
//        out_data/out_valid/out_ready/out_last/out_row/out_col stream to the sink;
//        busy (capturing or streaming), stream_done (pulse), overrun (sticky).
module matrix_result_streamer
    import matrix_pkg::*;
#(
    parameter  int SIZE   = 4,
    parameter  int DATA_W = DATA_W_DEF,
    localparam int IW     = idx_w(SIZE)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [0:SIZE-1][0:SIZE-1][DATA_W-1:0]   mat,
    input  logic                                     mat_done,
    output logic [DATA_W-1:0]                        out_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic                                     out_last,
    output logic [IW-1:0]                            out_row,
    output logic [IW-1:0]                            out_col,
    output logic                                     busy,
    output logic                                     stream_done,
    output logic                                     overrun
);

    localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

    state_t                                   state;
    state_t                                   state_nxt;
    logic [0:SIZE-1][0:SIZE-1][DATA_W-1:0]   snap;
    logic [IW-1:0]                            row;
    logic [IW-1:0]                            col;
    logic                                     mat_rise;
    logic                                     hs;
    logic                                     at_end;

    rise_detect u_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (mat_done),
        .rise  (mat_rise)
    );

    assign hs     = (state == ST_STREAM) && out_ready;
    assign at_end = (row == LAST_IDX) && (col == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (mat_rise) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_STREAM;
            ST_STREAM:  if (hs && at_end) state_nxt = ST_FINISH;
            ST_FINISH:  state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Indices return to 0 after the last element so idle outputs read [0][0].
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (state == ST_CAPTURE) begin
            row <= '0;
            col <= '0;
        end else if (hs) begin
            if (at_end) begin
                row <= '0;
                col <= '0;
            end else if (col == LAST_IDX) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Snapshot decouples the stream from later changes to mat; no reset needed.
    always_ff @(posedge clk) begin
        if (state == ST_CAPTURE) begin
            snap <= mat;
        end
    end

    // Any new result arriving while a previous one is still in flight
    // (including the FINISH cycle) is dropped and flagged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (mat_rise && (state != ST_IDLE)) begin
            overrun <= 1'b1;
        end
    end

    assign out_valid   = (state == ST_STREAM);
    assign out_data    = out_valid ? snap[row][col] : '0;
    assign out_row     = row;
    assign out_col     = col;
    assign out_last    = out_valid && at_end;
    assign busy        = (state == ST_CAPTURE) || (state == ST_STREAM);
    assign stream_done = (state == ST_FINISH);

endmodule
